// File: rtl/fp_div_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp_div_pkg
// Description : Shared types and constants for the Newton-Raphson FP divider.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_div_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [31:0] POS_INF    = 32'h7F800000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SEED  = 4'd1,
        ST_MUL_T = 4'd2,
        ST_MUL_X = 4'd3,
        ST_QMUL  = 4'd4,
        ST_CORR  = 4'd5,
        ST_PACK  = 4'd6,
        ST_DONE  = 4'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_div_seed_rom.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_seed_rom
// Description : Reciprocal seed table, one Q1.WF entry per mantissa bin midpoint.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_seed_rom #(
    parameter int SEED_BITS = 4,
    parameter int WF        = 30
) (
    input  logic [SEED_BITS-1:0] i_idx,
    output logic [WF:0]          o_seed
);

    localparam int              c_entries = 2 ** SEED_BITS;
    localparam longint unsigned c_num     = 64'd1 << (WF + SEED_BITS + 1);

    logic [WF:0] w_table [c_entries];

    // Midpoint of bin i is (2^(S+1) + 2i + 1) / 2^(S+1); the entry is its reciprocal.
    for (genvar gi = 0; gi < c_entries; gi++) begin : g_entry
        localparam longint unsigned c_den = longint'((1 << (SEED_BITS + 1)) + 2 * gi + 1);
        assign w_table[gi] = (WF + 1)'(c_num / c_den);
    end

    assign o_seed = w_table[i_idx];

endmodule
`default_nettype wire

// File: rtl/fp_nr_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp_nr_divider
// Description : Iterative IEEE single divider (RTZ, FTZ) using Newton-Raphson
//               reciprocal refinement and a remainder fix-up; one op in flight.
//               Define FPDIV_FLAGS_EN to add the registered out_flags port.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_nr_divider
    import fp_div_pkg::*;
#(
    parameter int ITERS     = 3,
    parameter int SEED_BITS = 4,
    parameter int WF        = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
`ifdef FPDIV_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] out_flags
`endif
);

    localparam int c_mul_w = WF + 2;
    localparam int c_est_w = 26;

    state_t              r_state;
    logic [2:0]          r_iter;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [WF:0]         r_x;
    logic [WF+1:0]       r_t;
    logic [c_est_w-1:0]  r_est;
    logic                r_rem_nz;

    logic [MANT_W-1:0]      w_ma;
    logic [MANT_W-1:0]      w_mb;
    logic [WF:0]            w_seed;
    logic [WF+1:0]          w_two_minus_t;
    logic [c_mul_w-1:0]     w_mul_a;
    logic [c_mul_w-1:0]     w_mul_b;
    logic [2*c_mul_w-1:0]   w_prod;
    logic                   w_unused;

    assign in_ready = (r_state == ST_IDLE);

    // ---------------------------------------------------------------- classify
    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic             w_sign;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_special;
    logic [31:0]      w_spec_result;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_ma     = {1'b1, r_a[FRAC_W-1:0]};
    assign w_mb     = {1'b1, r_b[FRAC_W-1:0]};
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (r_a[FRAC_W-1:0] == '0);
    assign w_b_inf  = (w_eb == '1) && (r_b[FRAC_W-1:0] == '0);
    assign w_a_nan  = (w_ea == '1) && (r_a[FRAC_W-1:0] != '0);
    assign w_b_nan  = (w_eb == '1) && (r_b[FRAC_W-1:0] != '0);

`ifdef FPDIV_FLAGS_EN
    logic [FLAG_W-1:0] w_spec_flags;
    logic [FLAG_W-1:0] w_pack_flags;
`endif

    always_comb begin
        w_special     = 1'b1;
        w_spec_result = '0;
`ifdef FPDIV_FLAGS_EN
        w_spec_flags  = '0;
`endif
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_result = QNAN;
`ifdef FPDIV_FLAGS_EN
            w_spec_flags[FLAG_NV] = 1'b1;
`endif
        end else if (w_a_inf) begin
            w_spec_result = {w_sign, POS_INF[30:0]};
        end else if (w_b_zero) begin
            w_spec_result = {w_sign, POS_INF[30:0]};
`ifdef FPDIV_FLAGS_EN
            w_spec_flags[FLAG_DZ] = 1'b1;
`endif
        end else if (w_a_zero || w_b_inf) begin
            w_spec_result = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    fp_div_seed_rom #(
        .SEED_BITS (SEED_BITS),
        .WF        (WF)
    ) u_seed_rom (
        .i_idx  (r_b[FRAC_W-1 -: SEED_BITS]),
        .o_seed (w_seed)
    );

    // ---------------------------------------------------- shared multiplier
    assign w_two_minus_t = {2'b10, {WF{1'b0}}} - r_t;

    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            ST_MUL_T: begin w_mul_a = c_mul_w'(w_mb);  w_mul_b = c_mul_w'(r_x);        end
            ST_MUL_X: begin w_mul_a = c_mul_w'(r_x);   w_mul_b = w_two_minus_t;        end
            ST_QMUL:  begin w_mul_a = c_mul_w'(w_ma);  w_mul_b = c_mul_w'(r_x);        end
            ST_CORR:  begin w_mul_a = c_mul_w'(r_est); w_mul_b = c_mul_w'(w_mb);       end
            default:  begin w_mul_a = '0;              w_mul_b = '0;                   end
        endcase
    end

    assign w_prod   = (2 * c_mul_w)'(w_mul_a) * (2 * c_mul_w)'(w_mul_b);
    assign w_unused = ^w_prod;

    // ------------------------------------------------------ remainder fix-up
    // The reciprocal leaves est within one of the true quotient, so one step suffices.
    logic [51:0] w_num, w_rem, w_mb_ext, w_rem_fix;
    logic        w_rem_neg, w_rem_ge;

    assign w_num     = {3'b000, w_ma, 25'd0};
    assign w_mb_ext  = {28'd0, w_mb};
    assign w_rem     = w_num - w_prod[51:0];
    assign w_rem_neg = w_rem[51];
    assign w_rem_ge  = !w_rem_neg && (w_rem >= w_mb_ext);
    assign w_rem_fix = w_rem_neg ? (w_rem + w_mb_ext) :
                       w_rem_ge  ? (w_rem - w_mb_ext) : w_rem;

    // ------------------------------------------------------------------ pack
    logic signed [9:0] w_exp_raw, w_exp;
    logic [FRAC_W-1:0] w_mant;
    logic              w_disc;
    logic [31:0]       w_pack_result;

    assign w_exp_raw = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

    always_comb begin
        w_exp  = r_est[25] ? w_exp_raw : (w_exp_raw - 10'sd1);
        w_mant = r_est[25] ? r_est[24:2] : r_est[23:1];
        w_disc = r_est[25] ? (|r_est[1:0]) : r_est[0];
        w_pack_result = {w_sign, w_exp[7:0], w_mant};
`ifdef FPDIV_FLAGS_EN
        w_pack_flags = '0;
        w_pack_flags[FLAG_NX] = r_rem_nz | w_disc;
`endif
        if (w_exp >= 10'sd255) begin
            w_pack_result = {w_sign, MAX_FINITE[30:0]};
`ifdef FPDIV_FLAGS_EN
            w_pack_flags[FLAG_OF] = 1'b1;
            w_pack_flags[FLAG_NX] = 1'b1;
`endif
        end else if (w_exp <= 10'sd0) begin
            w_pack_result = {w_sign, 31'd0};
`ifdef FPDIV_FLAGS_EN
            w_pack_flags[FLAG_UF] = 1'b1;
            w_pack_flags[FLAG_NX] = 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_iter     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_x        <= '0;
            r_t        <= '0;
            r_est      <= '0;
            r_rem_nz   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef FPDIV_FLAGS_EN
            out_flags  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_state <= ST_SEED;
                    end
                end
                // Special operands short-cut straight to DONE from here.
                ST_SEED: begin
                    if (w_special) begin
                        out_result <= w_spec_result;
`ifdef FPDIV_FLAGS_EN
                        out_flags  <= w_spec_flags;
`endif
                        out_valid  <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_x     <= w_seed;
                        r_iter  <= '0;
                        r_state <= ST_MUL_T;
                    end
                end
                ST_MUL_T: begin
                    r_t     <= w_prod[FRAC_W +: WF + 2];
                    r_state <= ST_MUL_X;
                end
                ST_MUL_X: begin
                    r_x <= w_prod[WF +: WF + 1];
                    if (r_iter == 3'(ITERS - 1)) begin
                        r_state <= ST_QMUL;
                    end else begin
                        r_iter  <= r_iter + 3'd1;
                        r_state <= ST_MUL_T;
                    end
                end
                ST_QMUL: begin
                    r_est   <= w_prod[WF - 2 +: c_est_w];
                    r_state <= ST_CORR;
                end
                ST_CORR: begin
                    r_est    <= w_rem_neg ? (r_est - 26'd1) :
                                w_rem_ge  ? (r_est + 26'd1) : r_est;
                    r_rem_nz <= |w_rem_fix;
                    r_state  <= ST_PACK;
                end
                ST_PACK: begin
                    out_result <= w_pack_result;
`ifdef FPDIV_FLAGS_EN
                    out_flags  <= w_pack_flags;
`endif
                    out_valid  <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_nr_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_nr_divider
// Description : Scoreboard bench for fp_nr_divider against a real-valued RTZ model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_nr_divider;
    import fp_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
`ifdef FPDIV_FLAGS_EN
    logic [4:0]  out_flags;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fp_nr_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FPDIV_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic [4:0] fl);
        exp_t e;
        e.res = res;
        e.fl  = fl;
        return e;
    endfunction

    // Independent model: exact double quotient truncated to single precision.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        az, bz, ai, bi, an, bn, nx;
        real         ra, rb, rq;
        logic [63:0] qb;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        az = (ea == 8'd0);   bz = (eb == 8'd0);
        ai = (ea == 8'hFF) && (fa == 23'd0);
        bi = (eb == 8'hFF) && (fb == 23'd0);
        an = (ea == 8'hFF) && (fa != 23'd0);
        bn = (eb == 8'hFF) && (fb != 23'd0);
        if (an || bn || (az && bz) || (ai && bi)) return mk(32'h7FC00000, 5'b10000);
        if (ai) return mk({s, 31'h7F800000}, 5'b00000);
        if (bz) return mk({s, 31'h7F800000}, 5'b01000);
        if (az || bi) return mk({s, 31'd0}, 5'b00000);
        ra = $bitstoreal({1'b0, 11'(ea) + 11'd896, fa, 29'd0});
        rb = $bitstoreal({1'b0, 11'(eb) + 11'd896, fb, 29'd0});
        rq = ra / rb;
        qb = $realtobits(rq);
        e  = int'(qb[62:52]) - 896;
        nx = |qb[28:0];
        if (e >= 255) return mk({s, 31'h7F7FFFFF}, 5'b00101);
        if (e <= 0)   return mk({s, 31'd0}, 5'b00011);
        return mk({s, e[7:0], qb[51:29]}, {4'b0000, nx});
    endfunction

    always @(negedge clk) begin : p_mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("result", out_result, e.res);
`ifdef FPDIV_FLAGS_EN
                check("flags", 32'(out_flags), 32'(e.fl));
`endif
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t e,
                          input int lat, input int hold);
        int          cyc;
        logic [31:0] held;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check("idle_before", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        held = out_result;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            in_a = $urandom;
            in_b = $urandom;
            @(posedge clk); #1;
            check("hold_result", out_result, held);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin : p_wdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : p_main
        logic [31:0] a, b;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", out_result, 32'd0);
`ifdef FPDIV_FLAGS_EN
        check("rst_flags", 32'(out_flags), 32'd0);
`endif

        run_op(32'h40C00000, 32'h40000000, mk(32'h40400000, 5'b00000), 10, 0);
        run_op(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 5'b00001), 10, 0);
        run_op(32'h3F800000, 32'h00000000, mk(32'h7F800000, 5'b01000), 1, 0);
        run_op(32'h00000000, 32'h00000000, mk(32'h7FC00000, 5'b10000), 1, 0);
        run_op(32'hC0000000, 32'h7F800000, mk(32'h80000000, 5'b00000), 1, 0);
        run_op(32'h00000001, 32'h3F800000, mk(32'h00000000, 5'b00000), 1, 0);
        run_op(32'h7F7FFFFF, 32'h3F000000, mk(32'h7F7FFFFF, 5'b00101), 10, 0);
        run_op(32'h00800000, 32'h40000000, mk(32'h00000000, 5'b00011), 10, 0);

        // Backpressure window with stray in_valid pulses.
        run_op(32'h41200000, 32'h40400000, ref_div(32'h41200000, 32'h40400000), 10, 5);

        // Abort an operation with a one-cycle reset.
        while (!in_ready) begin @(posedge clk); #1; end
        in_a = 32'h40C00000; in_b = 32'h40000000; in_valid = 1'b1;
        sb_q.push_back(mk(32'h40400000, 5'b00000));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(sb_q.pop_back());
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        run_op(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 5'b00001), 10, 0);

        for (int i = 0; i < 1000; i++) begin
            a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            if ((i % 16) == 0) b[22:0] = 23'd0;
            if ((i % 16) == 1) b[22:0] = 23'h7FFFFF;
            if ((i % 16) == 2) a[22:0] = 23'h7FFFFF;
            run_op(a, b, ref_div(a, b), 10, 0);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
